fifo_param: RTL and testbench



---
 rtl/fifo_param.sv | 94 +++++++++
 tb/tb_fifo_param.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO on a register array, with occupancy,
// threshold flags, error pulses and an optional first-word-fall-through read.
module fifo_param #(
   parameter int WIDTH    = 8,
   parameter int ADDR_W   = 4,
   parameter int AF_LEVEL = 14,
   parameter int AE_LEVEL = 2,
   parameter int FWFT     = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              write,
   input  logic [WIDTH-1:0]  inputBus,
   input  logic              read,
   output logic [WIDTH-1:0]  outputBus,
   output logic              empty,
   output logic              full,
   output logic              almost_empty,
   output logic              almost_full,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_CNT = DEPTH[ADDR_W:0];
   localparam logic [ADDR_W:0] AF_CNT    = AF_LEVEL[ADDR_W:0];
   localparam logic [ADDR_W:0] AE_CNT    = AE_LEVEL[ADDR_W:0];

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              rd_acc;
   logic              wr_acc;

   // A full FIFO still takes a write when a read frees a slot this edge.
   assign rd_acc = read & ~empty;
   assign wr_acc = write & (~full | rd_acc);

   assign empty        = (count == '0);
   assign full         = (count == DEPTH_CNT);
   assign almost_empty = (count <= AE_CNT);
   assign almost_full  = (count >= AF_CNT);

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr] <= inputBus;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= write & ~wr_acc;
         underflow <= read & ~rd_acc;
         if (wr_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign outputBus = empty ? '0 : mem[rd_ptr];
      end else begin : g_reg
         logic [WIDTH-1:0] dout;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               dout <= '0;
            end else if (rd_acc) begin
               dout <= mem[rd_ptr];
            end
         end

         assign outputBus = dout;
      end
   endgenerate

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: registered-read instance driven from a vector table,
// plus a first-word-fall-through instance checked across pointer wraps.
module tb_fifo_param;

   localparam int W  = 8;
   localparam int AW = 4;
   localparam int D  = 16;
   localparam int AF = 14;
   localparam int AE = 2;

   typedef struct {
      logic       wr;
      logic       rd;
      logic [7:0] din;
      int         cnt;
      logic       ov;
      logic       un;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   logic         w0 = 1'b0, r0 = 1'b0;
   logic [W-1:0] d0 = '0;
   logic [W-1:0] o0;
   logic         e0, f0, ae0, af0, ov0, un0;
   logic [AW:0]  c0;

   logic         w1 = 1'b0, r1 = 1'b0;
   logic [W-1:0] d1 = '0;
   logic [W-1:0] o1;
   logic         e1, f1, ae1, af1, ov1, un1;
   logic [AW:0]  c1;

   vec_t       tbl[$];
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic [7:0] exp0 = '0;
   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fifo_param #(.WIDTH(W), .ADDR_W(AW), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) dut0 (
      .clk(clk), .reset(reset), .write(w0), .inputBus(d0), .read(r0),
      .outputBus(o0), .empty(e0), .full(f0), .almost_empty(ae0),
      .almost_full(af0), .count(c0), .overflow(ov0), .underflow(un0)
   );

   fifo_param #(.WIDTH(W), .ADDR_W(AW), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) dut1 (
      .clk(clk), .reset(reset), .write(w1), .inputBus(d1), .read(r1),
      .outputBus(o1), .empty(e1), .full(f1), .almost_empty(ae1),
      .almost_full(af1), .count(c1), .overflow(ov1), .underflow(un1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   function automatic void add(input logic wr, input logic rd, input logic [7:0] din,
                               input int cnt, input logic ov, input logic un);
      vec_t v;
      v.wr = wr; v.rd = rd; v.din = din; v.cnt = cnt; v.ov = ov; v.un = un;
      tbl.push_back(v);
   endfunction

   task automatic chk_flags0(input string tag, input int cnt);
      chk({tag, " count"}, 32'(c0), 32'(cnt));
      chk({tag, " empty"}, 32'(e0), 32'(cnt == 0));
      chk({tag, " full"}, 32'(f0), 32'(cnt == D));
      chk({tag, " almost_empty"}, 32'(ae0), 32'(cnt <= AE));
      chk({tag, " almost_full"}, 32'(af0), 32'(cnt >= AF));
   endtask

   task automatic run_tbl();
      foreach (tbl[i]) begin
         vec_t v;
         bit rok, wok;
         string tag;
         v = tbl[i];
         tag = $sformatf("vec%0d", i);
         w0 = v.wr; r0 = v.rd; d0 = v.din;
         rok = v.rd && (q0.size() > 0);
         wok = v.wr && ((q0.size() < D) || rok);
         if (rok) exp0 = q0.pop_front();
         if (wok) q0.push_back(v.din);
         @(posedge clk); #1;
         chk_flags0(tag, v.cnt);
         chk({tag, " overflow"}, 32'(ov0), 32'(v.ov));
         chk({tag, " underflow"}, 32'(un0), 32'(v.un));
         chk({tag, " outputBus"}, 32'(o0), 32'(exp0));
      end
      w0 = 1'b0; r0 = 1'b0; d0 = '0;
      tbl.delete();
   endtask

   initial begin
      // Reset and idle
      repeat (2) @(posedge clk);
      #1;
      chk_flags0("reset", 0);
      chk("reset outputBus", 32'(o0), 32'h0);
      chk("reset overflow", 32'(ov0), 32'h0);
      chk("reset underflow", 32'(un0), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      chk_flags0("idle", 0);
      chk("idle outputBus", 32'(o0), 32'h0);

      // Fill, overflow, drain, underflow
      for (int i = 0; i < D; i++) add(1, 0, 8'(i + 1), i + 1, 0, 0);
      add(1, 0, 8'hAA, D, 1, 0);
      add(0, 0, 8'h00, D, 0, 0);
      for (int i = 0; i < D; i++) add(0, 1, 8'h00, D - 1 - i, 0, 0);
      add(0, 1, 8'h00, 0, 0, 1);
      add(0, 0, 8'h00, 0, 0, 0);
      // Refill, read+write on full, drain
      for (int i = 0; i < D; i++) add(1, 0, 8'(i + 1), i + 1, 0, 0);
      add(1, 1, 8'h55, D, 0, 0);
      for (int i = 0; i < D; i++) add(0, 1, 8'h00, D - 1 - i, 0, 0);
      // Read+write on empty
      add(1, 1, 8'h33, 1, 0, 1);
      add(0, 1, 8'h00, 0, 0, 0);
      add(0, 0, 8'h00, 0, 0, 0);
      // Build up count 5 with a non-zero outputBus
      for (int i = 0; i < 6; i++) add(1, 0, 8'(8'hC0 + i), i + 1, 0, 0);
      add(0, 1, 8'h00, 5, 0, 0);
      run_tbl();

      // Asynchronous reset mid-stream, checked before the next edge
      w0 = 1'b1; d0 = 8'hEE;
      #1 reset = 1'b1;
      #1;
      chk_flags0("async", 0);
      chk("async outputBus", 32'(o0), 32'h0);
      chk("async overflow", 32'(ov0), 32'h0);
      chk("async underflow", 32'(un0), 32'h0);
      @(negedge clk);
      w0 = 1'b0; d0 = '0;
      reset = 1'b0;
      q0.delete();
      exp0 = '0;
      @(posedge clk); #1;
      chk_flags0("post_reset", 0);

      // First-word-fall-through instance
      chk("fwft empty outputBus", 32'(o1), 32'h0);
      w1 = 1'b1; d1 = 8'h7E;
      q1.push_back(8'h7E);
      @(posedge clk); #1;
      w1 = 1'b0;
      chk("fwft first word", 32'(o1), 32'h7E);
      chk("fwft first count", 32'(c1), 32'd1);
      @(posedge clk); #1;
      chk("fwft first hold", 32'(o1), 32'h7E);

      for (int i = 0; i < 40; i++) begin
         bit rok, wok, exp_ov, exp_un;
         string tag;
         tag = $sformatf("fwft%0d", i);
         w1 = 1'b1;
         r1 = (i % 4) != 0;
         d1 = 8'($urandom);
         rok = r1 && (q1.size() > 0);
         wok = w1 && ((q1.size() < D) || rok);
         exp_ov = w1 && !wok;
         exp_un = r1 && !rok;
         if (rok) void'(q1.pop_front());
         if (wok) q1.push_back(d1);
         @(posedge clk); #1;
         chk({tag, " outputBus"}, 32'(o1), 32'((q1.size() > 0) ? q1[0] : 8'h00));
         chk({tag, " count"}, 32'(c1), 32'(q1.size()));
         chk({tag, " empty"}, 32'(e1), 32'(q1.size() == 0));
         chk({tag, " full"}, 32'(f1), 32'(q1.size() == D));
         chk({tag, " almost_empty"}, 32'(ae1), 32'(q1.size() <= AE));
         chk({tag, " almost_full"}, 32'(af1), 32'(q1.size() >= AF));
         chk({tag, " overflow"}, 32'(ov1), 32'(exp_ov));
         chk({tag, " underflow"}, 32'(un1), 32'(exp_un));
      end
      w1 = 1'b0;

      // Drain the fall-through instance completely
      r1 = 1'b1;
      while (q1.size() > 0) begin
         void'(q1.pop_front());
         @(posedge clk); #1;
         chk("fwft drain outputBus", 32'(o1), 32'((q1.size() > 0) ? q1[0] : 8'h00));
         chk("fwft drain count", 32'(c1), 32'(q1.size()));
      end
      r1 = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
